// File: rtl/uart_tx_responder_if.sv
// -----------------------------------------------------------------------------
// uart_tx_responder_if
// Purpose : CPU data-bus bundle for the memory-mapped UART transmitter.
// Signals :
//   rd    - read strobe, valid for the whole cycle
//   wr    - write strobe, commits on the rising clock edge
//   addr  - 32-bit byte address
//   wdata - 32-bit write data
//   rdata - 32-bit combinational read data from the responder
// Modports: master (CPU side), slave (responder side).
// -----------------------------------------------------------------------------
interface uart_tx_responder_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, output wr, output addr, output wdata, input rdata);
    modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_tx_responder.sv
// -----------------------------------------------------------------------------
// uart_tx_responder
// Purpose : Memory-mapped UART transmitter. The CPU pushes bytes into a small
//           FIFO through TXD; a baud-timed FSM sends them LSB first on uart_tx.
//           STAT/CTRL give status, sticky flags and the interrupt enable.
// Ports   :
//   clk     - system clock, rising-edge active
//   reset   - asynchronous active-low reset
//   bus     - uart_tx_responder_if.slave (rd, wr, addr, wdata, rdata)
//   uart_tx - serial line, idles high (registered)
//   tx_irq  - level interrupt, irq_en & done (registered)
// Registers: TXD @BASE (W), STAT @BASE+4 (R, read clears done/ovf),
//            CTRL @BASE+8 (R/W, bit0 irq_en).
// Option  : define UART_TX_PARITY_EN to add an even-parity bit (11-bit frame,
//           STAT bit5 reads 1).
// -----------------------------------------------------------------------------
module uart_tx_responder #(
    parameter logic [31:0] BASE         = 32'h40000018,
    parameter int          CLKS_PER_BIT = 5208,
    parameter int          DEPTH        = 4
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_responder_if.slave bus,
    output logic             uart_tx,
    output logic             tx_irq
);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = PW + 1;
    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic       PAR_FLAG = 1'b1;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`else
    localparam logic       PAR_FLAG = 1'b0;
`endif

    logic [7:0]      fifo_q [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            done_q, done_d, ovf_q, ovf_d, irq_en_q, irq_en_d;
    logic            tx_q, tx_d, irq_q;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif

    logic sel_txd_s, sel_stat_s, sel_ctrl_s;
    logic push_s, pop_s, full_s, empty_s, bit_end_s, done_set_s, ovf_set_s;
    logic [7:0]  head_s;
    logic [31:0] stat_s;
    logic unused_s;

    assign sel_txd_s  = (bus.addr == BASE);
    assign sel_stat_s = (bus.addr == BASE + 32'd4);
    assign sel_ctrl_s = (bus.addr == BASE + 32'd8);
    assign full_s     = (count_q == CNTW'(DEPTH));
    assign empty_s    = (count_q == {CNTW{1'b0}});
    assign head_s     = fifo_q[rptr_q];
    assign bit_end_s  = (baud_q == CW'(CLKS_PER_BIT - 1));
    assign unused_s   = ^bus.wdata[31:8];

    // Transmit FSM next state; pop_s marks a frame load from the FIFO head.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        pop_s      = 1'b0;
        done_set_s = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d = {CW{1'b0}};
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = head_s;
`ifdef UART_TX_PARITY_EN
                    par_d   = even_parity(head_s);
`endif
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    baud_d  = {CW{1'b0}};
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d  = baud_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    baud_d  = {CW{1'b0}};
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end_s) begin
                    baud_d  = {CW{1'b0}};
                    state_d = S_STOP;
                end else begin
                    baud_d  = baud_q + CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_end_s) begin
                    baud_d = {CW{1'b0}};
                    // Back-to-back: reload straight into START with no idle gap.
                    if (!empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = head_s;
`ifdef UART_TX_PARITY_EN
                        par_d   = even_parity(head_s);
`endif
                        state_d = S_START;
                    end else begin
                        done_set_s = 1'b1;
                        state_d    = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = {CW{1'b0}};
            end
        endcase
    end

    // Line level for the coming cycle, registered so uart_tx is glitch-free.
    always_comb begin
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // FIFO bookkeeping and sticky flags; a pop in the same cycle frees a slot.
    always_comb begin
        push_s    = bus.wr & sel_txd_s & (~full_s | pop_s);
        ovf_set_s = bus.wr & sel_txd_s & full_s & ~pop_s;
        wptr_d    = push_s ? wptr_q + PW'(1) : wptr_q;
        rptr_d    = pop_s  ? rptr_q + PW'(1) : rptr_q;
        count_d   = count_q + CNTW'(push_s) - CNTW'(pop_s);
        // A set in the same cycle as a STAT read clear wins.
        if (done_set_s) begin
            done_d = 1'b1;
        end else if (bus.rd & sel_stat_s) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (bus.rd & sel_stat_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (bus.wr & sel_ctrl_s) begin
            irq_en_d = bus.wdata[0];
        end else begin
            irq_en_d = irq_en_q;
        end
    end

    // Combinational read mux; zero unless a decoded register is being read.
    always_comb begin
        stat_s       = 32'd0;
        stat_s[31:8] = 24'(count_q);
        stat_s[5]    = PAR_FLAG;
        stat_s[4]    = ovf_q;
        stat_s[3]    = done_q;
        stat_s[2]    = empty_s;
        stat_s[1]    = full_s;
        stat_s[0]    = (state_q != S_IDLE);
        if (bus.rd && sel_stat_s) begin
            bus.rdata = stat_s;
        end else if (bus.rd && sel_ctrl_s) begin
            bus.rdata = {31'd0, irq_en_q};
        end else begin
            bus.rdata = 32'd0;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= 8'd0;
        end else if (push_s) begin
            fifo_q[wptr_q] <= bus.wdata[7:0];
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q   <= {PW{1'b0}};
            rptr_q   <= {PW{1'b0}};
            count_q  <= {CNTW{1'b0}};
            state_q  <= S_IDLE;
            baud_q   <= {CW{1'b0}};
            idx_q    <= 3'd0;
            shift_q  <= 8'd0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            tx_q     <= 1'b1;
            irq_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            tx_q     <= tx_d;
            irq_q    <= irq_en_d & done_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign uart_tx = tx_q;
    assign tx_irq  = irq_q;
endmodule

// File: tb/tb_uart_tx_responder.sv
// Bench for uart_tx_responder: a frame-level reference model predicts register
// reads and the byte stream; a line monitor decodes uart_tx against the queue.
module tb_uart_tx_responder;
    localparam logic [31:0] BASE  = 32'h40000018;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int   NBITS = 11;
    localparam logic PAR   = 1'b1;
`else
    localparam int   NBITS = 10;
    localparam logic PAR   = 1'b0;
`endif
    localparam int FRAME = NBITS * CPB;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic uart_tx, tx_irq;
    uart_tx_responder_if bus_if ();

    uart_tx_responder #(.BASE(BASE), .CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus_if), .uart_tx(uart_tx), .tx_irq(tx_irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state (frame granularity).
    logic [7:0] mq[$];      // bytes held in the FIFO
    logic [7:0] exp_q[$];   // accepted bytes not yet seen on the line
    bit     m_busy = 0, m_done = 0, m_ovf = 0, m_irq_en = 0;
    longint m_cyc = 0, m_end = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a == BASE + 32'd4)
            return {24'(mq.size()), 2'b00, PAR, m_ovf, m_done,
                    (mq.size() == 0), (mq.size() == DEPTH), m_busy};
        else if (a == BASE + 32'd8)
            return {31'd0, m_irq_en};
        else
            return 32'd0;
    endfunction

    // Advance the model over one rising edge with the given bus inputs.
    task automatic model_step(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        bit set_done = 0, set_ovf = 0;
        if (!m_busy) begin
            if (mq.size() > 0) begin
                void'(mq.pop_front());
                m_busy = 1;
                m_end  = m_cyc + FRAME;
            end
        end else if (m_cyc == m_end) begin
            if (mq.size() > 0) begin
                void'(mq.pop_front());
                m_end = m_end + FRAME;
            end else begin
                m_busy   = 0;
                set_done = 1;
            end
        end
        if (wr && a == BASE) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(d[7:0]);
                exp_q.push_back(d[7:0]);
            end else begin
                set_ovf = 1;
            end
        end
        if (wr && a == BASE + 32'd8) m_irq_en = d[0];
        if (rd && a == BASE + 32'd4) begin
            m_done = 0;
            m_ovf  = 0;
        end
        if (set_done) m_done = 1;
        if (set_ovf)  m_ovf  = 1;
        m_cyc++;
    endtask

    task automatic cycle(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.rd = rd; bus_if.wr = wr; bus_if.addr = a; bus_if.wdata = d;
        #1;
        chk($sformatf("rdata@%h", a), bus_if.rdata, rd ? model_read(a) : 32'd0);
        chk("tx_irq", {31'd0, tx_irq}, {31'd0, m_irq_en & m_done});
        @(posedge clk);
        model_step(rd, wr, a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        cycle(1'b0, 1'b1, a, d);
    endtask

    task automatic rd_reg(input logic [31:0] a);
        cycle(1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (m_busy || mq.size() > 0); i++) idle(1);
        if (m_busy || mq.size() > 0) chk("drain_timeout", 32'd1, 32'd0);
        idle(3);
    endtask

    // Line monitor: decodes every frame cycle-exactly against the scoreboard.
    initial begin
        bit b2b = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                b2b = 0;
            end else begin
                if (b2b) chk("back_to_back_start", {31'd0, uart_tx}, 32'd0);
                b2b = 0;
                if (uart_tx === 1'b0) begin
                    logic [7:0] e;
                    logic       expbit [NBITS];
                    int         nbad;
                    bit         aborted;
                    e = 8'h00; nbad = 0; aborted = 0;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_frame: line low with no byte queued (t=%0t)", $time);
                    end else begin
                        e = exp_q.pop_front();
                    end
                    expbit[0] = 1'b0;
                    for (int k = 0; k < 8; k++) expbit[1 + k] = e[k];
                    if (PAR) expbit[9] = ^e;
                    expbit[NBITS - 1] = 1'b1;
                    for (int i = 0; i < FRAME; i++) begin
                        if (i > 0) @(negedge clk);
                        if (!reset) begin
                            aborted = 1;
                            break;
                        end
                        if (uart_tx !== expbit[i / CPB]) nbad++;
                    end
                    if (!aborted) begin
                        chk($sformatf("frame_bad_cycles byte %h", e), nbad, 32'd0);
                        b2b = (exp_q.size() > 0);
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        bus_if.rd = 1'b0; bus_if.wr = 1'b0; bus_if.addr = 32'd0; bus_if.wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
        chk("reset_tx_irq",  {31'd0, tx_irq},  32'd0);
        #2 reset = 1'b1;

        // Reset state through STAT and CTRL.
        rd_reg(BASE + 32'd4);
        rd_reg(BASE + 32'd8);
        rd_reg(BASE);

        // 0x55 frame with start latency of one edge.
        wr_reg(BASE, 32'h55);
        #1 chk("idle_before_start", {31'd0, uart_tx}, 32'd1);
        idle(1);
        #1 chk("start_latency", {31'd0, uart_tx}, 32'd0);
        idle(38);
        rd_reg(BASE + 32'd4);   // still busy in stop bit
        rd_reg(BASE + 32'd4);   // done just set
        rd_reg(BASE + 32'd4);   // done cleared
        rd_reg(BASE + 32'd12);

        // Interrupt path.
        wr_reg(BASE + 32'd8, 32'h1);
        wr_reg(BASE, 32'hA3);
        drain();
        rd_reg(BASE + 32'd4);
        idle(1);
        rd_reg(BASE + 32'd4);
        wr_reg(BASE + 32'd8, 32'h0);

        // Overflow: five writes while a frame is in flight.
        wr_reg(BASE, 32'h11);
        idle(3);
        wr_reg(BASE, 32'h22); wr_reg(BASE, 32'h33); wr_reg(BASE, 32'h44);
        wr_reg(BASE, 32'h66); wr_reg(BASE, 32'h77);
        rd_reg(BASE + 32'd4);
        rd_reg(BASE + 32'd4);
        drain();

        // Full FIFO: TXD write on the very edge the stop bit ends and pops.
        wr_reg(BASE, 32'h81);
        idle(2);
        wr_reg(BASE, 32'h82); wr_reg(BASE, 32'h83); wr_reg(BASE, 32'h84); wr_reg(BASE, 32'h85);
        rd_reg(BASE + 32'd4);
        for (int i = 0; i < 200 && m_cyc != m_end; i++) idle(1);
        wr_reg(BASE, 32'h86);
        rd_reg(BASE + 32'd4);
        drain();

`ifdef UART_TX_PARITY_EN
        wr_reg(BASE, 32'h07);
        drain();
        rd_reg(BASE + 32'd4);
`endif

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: wr_reg(BASE, {24'd0, 8'($urandom_range(0, 255))});
                4, 5:       rd_reg(BASE + 32'd4);
                6:          wr_reg(BASE + 32'd8, {31'd0, 1'($urandom_range(0, 1))});
                7: begin
                    case ($urandom_range(0, 3))
                        0:       rd_reg(BASE + 32'd8);
                        1:       rd_reg(BASE);
                        2:       rd_reg(BASE + 32'd12);
                        default: rd_reg($urandom);
                    endcase
                end
                default:    idle(int'($urandom_range(1, 30)));
            endcase
        end
        drain();
        rd_reg(BASE + 32'd4);

        // Reset in the middle of the data bits of 0x0F.
        wr_reg(BASE, 32'h0F);
        idle(15);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("reset_async_tx", {31'd0, uart_tx}, 32'd1);
        chk("reset_async_irq", {31'd0, tx_irq}, 32'd0);
        mq.delete(); exp_q.delete();
        m_busy = 0; m_done = 0; m_ovf = 0; m_irq_en = 0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        rd_reg(BASE + 32'd4);
        chk("stat_after_reset", model_read(BASE + 32'd4), 32'h00000004 | {26'd0, PAR, 5'd0});
        idle(20);
        #1 chk("idle_after_reset", {31'd0, uart_tx}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
